// File: rtl/data_mem_dma.sv
// rtl/data_mem_dma.sv - block copy/fill initiator for the data memory port
module data_mem_dma #(
  parameter int MEM_DEPTH = 1024,
  parameter int LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      fill_q, fill_d;
  logic [LEN_W-1:0] i_q, i_d;
  logic [31:0]      hold_q, hold_d;
  logic             err_q, err_d;

  // Range check on the raw command inputs; 33-bit sums so a huge base cannot wrap into range.
  logic [32:0] dst_end;
  logic [32:0] src_end;
  logic        reject;
  logic        last_word;

  assign dst_end   = {1'b0, dst_addr} + {{(33-LEN_W){1'b0}}, len};
  assign src_end   = {1'b0, src_addr} + {{(33-LEN_W){1'b0}}, len};
  assign reject    = (dst_end > 33'(MEM_DEPTH)) ||
                     ((mode == MODE_COPY) && (src_end > 33'(MEM_DEPTH)));
  assign last_word = (i_q == (len_q - LEN_W'(1)));

  // State, counter and latched command registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      i_q     <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      i_q     <= i_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode; memory-port outputs depend only on registered state.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    src_d          = src_q;
    dst_d          = dst_q;
    len_d          = len_q;
    fill_d         = fill_q;
    i_d            = i_q;
    hold_d         = hold_q;
    err_d          = err_q;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = len;
          fill_d = fill_value;
          i_d    = '0;
          err_d  = 1'b0;
          if (reject) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (len == '0) begin
            state_d = S_DONE;
          end else if (mode == MODE_COPY) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_READ: begin
        busy     = 1'b1;
        mem_addr = src_q + 32'(i_q);
        hold_d   = mem_read_data;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        busy           = 1'b1;
        mem_write_en   = 1'b1;
        mem_addr       = dst_q + 32'(i_q);
        mem_write_data = (mode_q == MODE_COPY) ? hold_q : fill_q;
        i_d            = i_q + LEN_W'(1);
        if (last_word) begin
          state_d = S_DONE;
        end else if (mode_q == MODE_COPY) begin
          state_d = S_READ;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        error   = err_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_dma.sv
// tb/tb_data_mem_dma.sv - self-checking bench for data_mem_dma with memory model and reference
module tb_data_mem_dma;

  localparam int DEPTH = 1024;
  localparam int LW    = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [LW-1:0] len;
  logic [31:0]   fill_value;
  logic          busy;
  logic          done;
  logic          error;
  logic          mem_write_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  logic [31:0]   mem     [0:DEPTH-1];
  logic [31:0]   exp_mem [0:DEPTH-1];
  logic          mem_init;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_dma #(.MEM_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
    .fill_value     (fill_value),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // External data memory: combinational read, write at the rising edge.
  assign mem_read_data = mem[mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= 32'h0000A123;
    end else if (mem_write_en) begin
      mem[mem_addr[9:0]] <= mem_write_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== exp_mem[k]) bad++;
    chk(tag, bad, 0);
  endtask

  // Reference: ascending word-by-word transfer, so overlapping copies re-read fresh data.
  task automatic model(input logic m, input logic [31:0] s, input logic [31:0] d, input int l,
                       input logic [31:0] f, output int busy_exp, output logic err_exp);
    longint dend;
    longint send;
    dend = longint'(d) + longint'(l);
    send = longint'(s) + longint'(l);
    err_exp  = 1'b0;
    busy_exp = 0;
    if (dend > DEPTH || (!m && send > DEPTH)) begin
      err_exp = 1'b1;
    end else if (l > 0) begin
      for (int k = 0; k < l; k++) exp_mem[d + k] = m ? f : exp_mem[s + k];
      busy_exp = m ? l : 2 * l;
    end
  endtask

  task automatic run_cmd(input string tag, input logic m, input logic [31:0] s,
                         input logic [31:0] d, input int l, input logic [31:0] f, input bit poke);
    int   busy_exp;
    logic err_exp;
    int   busy_cnt;
    int   we_cnt;
    int   done_at;
    bit   we_ok;
    logic err_seen;
    logic busy_in_done;
    logic port_idle;
    busy_cnt     = 0;
    we_cnt       = 0;
    done_at      = 0;
    we_ok        = 1'b1;
    err_seen     = 1'bx;
    busy_in_done = 1'bx;
    port_idle    = 1'b0;
    model(m, s, d, l, f, busy_exp, err_exp);
    mode       = m;
    src_addr   = s;
    dst_addr   = d;
    len        = LW'(l);
    fill_value = f;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    for (int n = 1; n <= 3000 && done_at == 0; n++) begin
      if (busy) busy_cnt++;
      if (mem_write_en) we_cnt++;
      if (!m && busy && (mem_write_en !== ((n % 2) == 0))) we_ok = 1'b0;
      if (done) begin
        done_at      = n;
        err_seen     = error;
        busy_in_done = busy;
        port_idle    = (mem_addr === 32'd0) && (mem_write_data === 32'd0) && (mem_write_en === 1'b0);
      end else begin
        if (poke && n == 2) begin
          start = 1'b1; mode = 1'b1; dst_addr = 32'd0; len = LW'(1); fill_value = 32'h5;
        end
        if (poke && n == 3) start = 1'b0;
        tick();
      end
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, done_at, (busy_exp == 0) ? 1 : busy_exp + 1);
    chk({tag, " busy_cycles"}, busy_cnt, busy_exp);
    chk({tag, " error"}, err_seen, err_exp);
    chk({tag, " busy_in_done"}, busy_in_done, 1'b0);
    chk({tag, " write_cycles"}, we_cnt, (busy_exp == 0) ? 0 : l);
    chk({tag, " we_pattern"}, we_ok, 1'b1);
    chk({tag, " port_idle_in_done"}, port_idle, 1'b1);
    tick();
    chk({tag, " done_pulse_width"}, done, 1'b0);
    cmp_mem({tag, " memory"});
  endtask

  initial begin
    int   l;
    logic m;
    logic [31:0] s;
    logic [31:0] d;

    rst        = 1'b0;
    start      = 1'b0;
    mode       = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    len        = '0;
    fill_value = '0;
    mem_init   = 1'b1;
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = 32'h0000A123;
    tick();
    tick();
    mem_init = 1'b0;

    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset error", error, 1'b0);
    chk("reset we", mem_write_en, 1'b0);
    chk("reset addr", mem_addr, 32'd0);
    chk("reset wdata", mem_write_data, 32'd0);
    rst = 1'b1;
    tick();

    run_cmd("fill8", 1'b1, 32'd0, 32'd8, 4, 32'hDEADBEEF, 1'b0);
    chk("fill8 w8", mem[8], 32'hDEADBEEF);
    chk("fill8 w11", mem[11], 32'hDEADBEEF);
    chk("fill8 w7", mem[7], 32'h0000A123);
    chk("fill8 w12", mem[12], 32'h0000A123);

    run_cmd("fill0", 1'b1, 32'd0, 32'd0, 3, 32'h11111111, 1'b0);
    run_cmd("copy100", 1'b0, 32'd0, 32'd100, 3, 32'h0, 1'b0);
    chk("copy w100", mem[100], 32'h11111111);
    chk("copy w102", mem[102], 32'h11111111);
    chk("copy w103", mem[103], 32'h0000A123);

    run_cmd("rej1020", 1'b1, 32'd0, 32'd1020, 8, 32'h12345678, 1'b0);
    run_cmd("len0", 1'b0, 32'd5, 32'd5, 0, 32'h0, 1'b0);

    run_cmd("fillA", 1'b1, 32'd0, 32'd0, 4, 32'hAAAAAAAA, 1'b0);
    run_cmd("overlap", 1'b0, 32'd0, 32'd1, 3, 32'h0, 1'b1);
    chk("overlap w0", mem[0], 32'hAAAAAAAA);
    chk("overlap w3", mem[3], 32'hAAAAAAAA);

    run_cmd("edge_ok", 1'b1, 32'd0, 32'd1000, 24, 32'hCAFEF00D, 1'b0);
    run_cmd("edge_rej", 1'b1, 32'd0, 32'd1000, 25, 32'hBAD0BAD0, 1'b0);
    run_cmd("src_rej", 1'b0, 32'd1020, 32'd0, 5, 32'h0, 1'b0);
    run_cmd("wrap_rej", 1'b1, 32'd0, 32'hFFFFFFF0, 32, 32'h99999999, 1'b0);
    run_cmd("last_word", 1'b1, 32'd0, 32'd1023, 1, 32'h0BADCAFE, 1'b0);

    // Reset in the 5th busy cycle of an 8-word copy: only the first two words land.
    exp_mem[300] = exp_mem[0];
    exp_mem[301] = exp_mem[1];
    mode     = 1'b0;
    src_addr = 32'd0;
    dst_addr = 32'd300;
    len      = LW'(8);
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    chk("midrst busy_before", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst we", mem_write_en, 1'b0);
    chk("midrst addr", mem_addr, 32'd0);
    chk("midrst wdata", mem_write_data, 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("midrst no_done", done, 1'b0);
    end
    rst = 1'b1;
    tick();
    for (int n = 0; n < 4; n++) begin
      chk("postrst no_done", done, 1'b0);
      tick();
    end
    cmp_mem("midrst memory");
    run_cmd("postrst_fill", 1'b1, 32'd0, 32'd300, 2, 32'h77777777, 1'b0);

    for (int r = 0; r < 25; r++) begin
      m = 1'b1 ^ 1'b0 ^ $urandom_range(0, 1) ? 1'b1 : 1'b0;
      l = $urandom_range(0, 20);
      s = $urandom_range(0, DEPTH - 1);
      d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, DEPTH - 1);
      run_cmd("rand", m, s, d, l, $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
